// File: rtl/unpacker_if.sv
// Handshake bundle between the word FIFO / TX byte FIFO and the unpacker.
// The master side is the unpacker itself; the slave side is the FIFO environment.
interface unpacker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 128
);
  logic [WORD_WIDTH-1:0] word_in;
  logic                  word_fifo_empty;
  logic                  word_rd_en;
  logic                  byte_fifo_full;
  logic [DATA_WIDTH-1:0] byte_out;
  logic                  byte_wr_en;
  logic                  word_done;
  logic                  busy;

  modport master (
    input  word_in, word_fifo_empty, byte_fifo_full,
    output word_rd_en, byte_out, byte_wr_en, word_done, busy
  );

  modport slave (
    output word_in, word_fifo_empty, byte_fifo_full,
    input  word_rd_en, byte_out, byte_wr_en, word_done, busy
  );
endinterface

// File: rtl/unpacker.sv
// Pops one wide word at a time from the word FIFO and streams it out LSB byte
// first into the TX byte FIFO, honouring empty/full so neither FIFO can under/overflow.
module unpacker #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 128
) (
  input  logic       clk,
  input  logic       rst,
  unpacker_if.master bus
);
  localparam int BYTES_PER_WORD = WORD_WIDTH / DATA_WIDTH;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

  if (WORD_WIDTH % DATA_WIDTH != 0) begin : gBadWidth
    $error("unpacker: WORD_WIDTH must be an integer multiple of DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

  state_t                state_q;
  logic [WORD_WIDTH-1:0] shiftReg_q;
  logic [CNT_W-1:0]      byteIdx_q;
  logic                  wordDone_q;
  logic                  wordRdEn;
  logic                  byteWrEn;

  // Strobes react to the FIFO flags in the same cycle; reset masks them outright.
  always_comb begin
    wordRdEn = !rst && (state_q == IDLE) && !bus.word_fifo_empty;
    byteWrEn = !rst && (state_q == SEND) && !bus.byte_fifo_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      byteIdx_q  <= '0;
      wordDone_q <= 1'b0;
    end else begin
      wordDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wordRdEn) state_q <= FETCH;
        end
        FETCH: begin
          state_q <= LOAD;
        end
        LOAD: begin
          shiftReg_q <= bus.word_in;
          byteIdx_q  <= '0;
          state_q    <= SEND;
        end
        SEND: begin
          // A stalled byte stays parked in the low lane of the shift register.
          if (byteWrEn) begin
            shiftReg_q <= shiftReg_q >> DATA_WIDTH;
            if (byteIdx_q == LAST_IDX) begin
              byteIdx_q  <= '0;
              wordDone_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              byteIdx_q <= byteIdx_q + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.word_rd_en = wordRdEn;
  assign bus.byte_wr_en = byteWrEn;
  assign bus.byte_out   = shiftReg_q[DATA_WIDTH-1:0];
  assign bus.word_done  = wordDone_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_unpacker.sv
// Self-checking bench for the unpacker: per-cycle vector table, hand-written corner
// sequences, and a randomized packer-loopback run against a byte-stream reference model.
module tb_unpacker;
  localparam int DW  = 8;
  localparam int WW  = 128;
  localparam int BPW = WW / DW;

  typedef struct {
    logic       full;
    logic       expRd;
    logic       expWr;
    logic [7:0] expByte;
    logic       expDone;
    logic       expBusy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int testsRun  = 0;
  int failCount = 0;

  unpacker_if #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) bus ();

  unpacker #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Word FIFO model: data appears on word_in the cycle after the read strobe.
  logic [WW-1:0] fifoMem [256];
  int wrPtr = 0;
  int rdPtr = 0;

  assign bus.word_fifo_empty = (wrPtr == rdPtr);

  always @(posedge clk) begin
    if (bus.word_rd_en) begin
      bus.word_in <= fifoMem[rdPtr % 256];
      rdPtr       <= rdPtr + 1;
    end
  end

  // Byte sink and pulse counters, stamped with the cycle each byte was accepted.
  logic [7:0] sinkQ [$];
  int         sinkCyc [$];
  int         cyc     = 0;
  int         doneCnt = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.byte_wr_en) begin
      sinkQ.push_back(bus.byte_out);
      sinkCyc.push_back(cyc);
    end
    if (bus.word_done) doneCnt = doneCnt + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic fullIn);
    bus.byte_fifo_full = fullIn;
  endtask

  task automatic pushWord(input logic [WW-1:0] w);
    fifoMem[wrPtr % 256] = w;
    wrPtr = wrPtr + 1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitBytes(input int target, input int budget, input string name);
    int n = 0;
    while (sinkQ.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sinkQ.size() < target)
      checkOutput(name, sinkQ.size(), target);
  endtask

  function automatic logic [WW-1:0] mkWord(input logic [7:0] base);
    logic [WW-1:0] w;
    for (int i = 0; i < BPW; i++) w[8*i +: 8] = base + 8'(i);
    return w;
  endfunction

  vec_t       tbl [24];
  logic [7:0] randBytes [96];
  logic [7:0] expQ [$];
  int         sBase;
  int         dBase;
  int         n;

  initial begin
    bus.byte_fifo_full = 1'b0;

    // Cycle-by-cycle expectation for one word with a 3-cycle stall while byte 0x05 pends.
    n = 0;
    tbl[n] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}; n++;
    tbl[n] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}; n++;
    tbl[n] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}; n++;
    for (int k = 0; k < 5; k++) begin
      tbl[n] = '{1'b0, 1'b0, 1'b1, 8'(k), 1'b0, 1'b1}; n++;
    end
    for (int k = 0; k < 3; k++) begin
      tbl[n] = '{1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1}; n++;
    end
    for (int k = 5; k < 16; k++) begin
      tbl[n] = '{1'b0, 1'b0, 1'b1, 8'(k), 1'b0, 1'b1}; n++;
    end
    tbl[n] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}; n++;
    tbl[n] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}; n++;

    doReset();
    #2;
    checkOutput("resetByteOut", 32'(bus.byte_out), 32'h0);
    checkOutput("resetWrEn", 32'(bus.byte_wr_en), 32'h0);
    checkOutput("resetRdEn", 32'(bus.word_rd_en), 32'h0);
    checkOutput("resetBusy", 32'(bus.busy), 32'h0);
    checkOutput("resetDone", 32'(bus.word_done), 32'h0);

    @(negedge clk);
    sBase = sinkQ.size();
    dBase = doneCnt;
    pushWord(mkWord(8'h00));
    for (int r = 0; r < 24; r++) begin
      if (r > 0) @(negedge clk);
      applyStimulus(tbl[r].full);
      #2;
      checkOutput($sformatf("tblRdEn[%0d]", r), 32'(bus.word_rd_en), 32'(tbl[r].expRd));
      checkOutput($sformatf("tblWrEn[%0d]", r), 32'(bus.byte_wr_en), 32'(tbl[r].expWr));
      checkOutput($sformatf("tblByte[%0d]", r), 32'(bus.byte_out), 32'(tbl[r].expByte));
      checkOutput($sformatf("tblDone[%0d]", r), 32'(bus.word_done), 32'(tbl[r].expDone));
      checkOutput($sformatf("tblBusy[%0d]", r), 32'(bus.busy), 32'(tbl[r].expBusy));
    end
    checkOutput("tblByteCount", sinkQ.size() - sBase, BPW);
    checkOutput("tblDoneCount", doneCnt - dBase, 1);

    // Empty FIFO: nothing moves.
    doReset();
    for (int i = 0; i < 50; i++) begin
      #2;
      checkOutput("idleQuiet", 32'({bus.word_rd_en, bus.byte_wr_en, bus.busy}), 32'h0);
      @(negedge clk);
    end

    // Two words back-to-back: ordered stream and a 3-cycle bubble between them.
    doReset();
    sBase = sinkQ.size();
    dBase = doneCnt;
    pushWord(mkWord(8'h00));
    pushWord(mkWord(8'h10));
    waitBytes(sBase + 32, 200, "b2bTimeout");
    repeat (2) @(negedge clk);
    if (sinkQ.size() >= sBase + 32) begin
      for (int i = 0; i < 32; i++)
        checkOutput($sformatf("b2bByte[%0d]", i), 32'(sinkQ[sBase+i]), i);
      checkOutput("b2bGap", sinkCyc[sBase+16] - sinkCyc[sBase+15], 4);
    end
    checkOutput("b2bDoneCount", doneCnt - dBase, 2);

    // Full already asserted when SEND is entered: nothing written until it drops.
    doReset();
    sBase = sinkQ.size();
    pushWord(mkWord(8'h00));
    applyStimulus(1'b1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      checkOutput("stallNoWrite", 32'(bus.byte_wr_en), 32'h0);
      if (i >= 3) checkOutput("stallByte", 32'(bus.byte_out), 32'h0);
    end
    checkOutput("stallSinkEmpty", sinkQ.size() - sBase, 0);
    @(negedge clk);
    applyStimulus(1'b0);
    waitBytes(sBase + 16, 100, "stallTimeout");
    if (sinkQ.size() >= sBase + 16) begin
      checkOutput("stallFirstByte", 32'(sinkQ[sBase]), 32'h0);
      checkOutput("stallLastByte", 32'(sinkQ[sBase+15]), 32'h0F);
    end

    // Reset right after byte 0x07: the rest of that word is dropped.
    doReset();
    sBase = sinkQ.size();
    dBase = doneCnt;
    pushWord(mkWord(8'h00));
    waitBytes(sBase + 8, 100, "rstMidTimeout");
    rst = 1'b1;
    #2;
    checkOutput("rstMidWrGated", 32'(bus.byte_wr_en), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("rstMidOutputs",
      32'({bus.byte_out, bus.byte_wr_en, bus.word_rd_en, bus.busy, bus.word_done}), 32'h0);
    checkOutput("rstMidDoneCount", doneCnt - dBase, 0);
    @(negedge clk);
    pushWord(mkWord(8'h20));
    waitBytes(sBase + 24, 100, "rstNextTimeout");
    repeat (4) @(negedge clk);
    checkOutput("rstMidTotal", sinkQ.size() - sBase, 24);
    if (sinkQ.size() >= sBase + 24) begin
      for (int i = 0; i < 24; i++)
        checkOutput($sformatf("rstMidByte[%0d]", i), 32'(sinkQ[sBase+i]),
                    (i < 8) ? i : 32'h20 + (i - 8));
    end

    // Randomized loopback: bytes packed LSB-first into words must come back unchanged.
    doReset();
    sBase = sinkQ.size();
    dBase = doneCnt;
    expQ.delete();
    for (int i = 0; i < 96; i++) begin
      randBytes[i] = 8'($urandom_range(0, 255));
      expQ.push_back(randBytes[i]);
    end
    for (int j = 0; j < 6; j++) begin
      logic [WW-1:0] w;
      for (int i = 0; i < BPW; i++) w[8*i +: 8] = randBytes[BPW*j + i];
      pushWord(w);
    end
    n = 0;
    while (sinkQ.size() < sBase + 96 && n < 2000) begin
      applyStimulus($urandom_range(0, 3) == 0);
      @(negedge clk);
      n++;
    end
    applyStimulus(1'b0);
    repeat (3) @(negedge clk);
    checkOutput("loopCount", sinkQ.size() - sBase, 96);
    if (sinkQ.size() >= sBase + 96) begin
      for (int i = 0; i < 96; i++)
        checkOutput($sformatf("loopByte[%0d]", i), 32'(sinkQ[sBase+i]), 32'(expQ[i]));
    end
    checkOutput("loopDoneCount", doneCnt - dBase, 6);
    checkOutput("loopIdleBusy", 32'(bus.busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
